// File: rtl/twos_comp_to_signmag.sv
// Bit-serial two's-complement to sign/magnitude converter, LSB first, using the
// copy-until-first-one-then-invert rule. Fixed latency of WIDTH cycles per operand.
module twos_comp_to_signmag #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OUT_SIGN,
   output logic [WIDTH-1:0] OUT_MAG,
   output logic [1:0]       DBG_STATE
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high. IN_READY is high only in IDLE, OUT_VALID only in DONE; input changes in
   // other states and OUT_READY outside DONE have no effect.

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic             seen_one_q;
   logic             sign_r_q;
   logic             out_sign_q;
   logic [WIDTH-1:0] out_mag_q;
   logic             bit_d;

   // Negative operands invert every bit after the first 1 seen from the LSB.
   assign bit_d = (sign_r_q & seen_one_q) ? ~shift_q[0] : shift_q[0];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         seen_one_q <= 1'b0;
         sign_r_q   <= 1'b0;
         out_sign_q <= 1'b0;
         out_mag_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (IN_VALID) begin
                  shift_q    <= IN_DATA;
                  sign_r_q   <= IN_DATA[WIDTH-1];
                  cnt_q      <= '0;
                  seen_one_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               out_mag_q  <= {bit_d, out_mag_q[WIDTH-1:1]};
               shift_q    <= {1'b0, shift_q[WIDTH-1:1]};
               seen_one_q <= seen_one_q | shift_q[0];
               cnt_q      <= cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  out_sign_q <= sign_r_q;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign OUT_SIGN  = out_sign_q;
   assign OUT_MAG   = out_mag_q;
   assign DBG_STATE = state_q;

endmodule
